// File: rtl/if_fetch.sv
// Instruction fetch: PC in, four byte reads over an 8-bit synchronous port, {inst, pc} out.
// Latency: valid 5 cycles after PC accept; holds the PC generator while busy or holding a result.
module if_fetch #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_ce_i,
    output logic              pc_stall_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_din_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i,
    input  logic              flush_i
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [31:0]       inst_q;
    logic              cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            addr_q <= '0;
            inst_q <= 32'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            if (cap) inst_q[{cnt, 3'b000} +: 8] <= mem_din_i;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_nxt     = addr_q;
        cap          = 1'b0;
        mem_rd_o     = 1'b0;
        mem_addr_o   = '0;
        inst_valid_o = 1'b0;
        // A flush drops everything, including the byte arriving next cycle.
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_ce_i && !rst) begin
                        mem_rd_o   = 1'b1;
                        mem_addr_o = pc_i;
                        addr_nxt   = pc_i;
                        cnt_nxt    = 2'd0;
                        state_nxt  = FETCH;
                    end
                end
                FETCH: begin
                    cap = 1'b1;
                    if (cnt != 2'd3) begin
                        mem_rd_o   = 1'b1;
                        mem_addr_o = addr_q + ADDR_W'(cnt) + ADDR_W'(1);
                        cnt_nxt    = cnt + 2'd1;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    inst_valid_o = 1'b1;
                    if (id_ready_i) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign pc_stall_o = (state != IDLE);
    assign inst_o     = inst_valid_o ? inst_q : NOP_INST;
    assign inst_pc_o  = inst_valid_o ? addr_q : '0;

endmodule
